// File: rtl/axil_ctrl_master.sv
// AXI4-Lite initiator: converts one register read/write command into AW/W/B or AR/R
// handshakes and returns the completion on a response stream, one transaction at a time.
module axil_ctrl_master #(
  parameter int AXI_ADDR      = 8,
  parameter int BW_AXI        = 32,
  parameter int BWB_AXI       = BW_AXI / 8,
  parameter int TIMEOUT_W     = 16,
  parameter int TIMEOUT_LIMIT = 1000
) (
  input  logic                clk_control,
  input  logic                clk_control_rst_high,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [AXI_ADDR-1:0] cmd_addr,
  input  logic [BW_AXI-1:0]   cmd_wdata,
  input  logic [BWB_AXI-1:0]  cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [BW_AXI-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                busy,
  output logic                timeout,
  output logic [AXI_ADDR-1:0] control_M_AXI_AWADDR,
  output logic                control_M_AXI_AWVALID,
  input  logic                control_M_AXI_AWREADY,
  output logic [BW_AXI-1:0]   control_M_AXI_WDATA,
  output logic [BWB_AXI-1:0]  control_M_AXI_WSTRB,
  output logic                control_M_AXI_WVALID,
  input  logic                control_M_AXI_WREADY,
  input  logic [1:0]          control_M_AXI_BRESP,
  input  logic                control_M_AXI_BVALID,
  output logic                control_M_AXI_BREADY,
  output logic [AXI_ADDR-1:0] control_M_AXI_ARADDR,
  output logic                control_M_AXI_ARVALID,
  input  logic                control_M_AXI_ARREADY,
  input  logic [BW_AXI-1:0]   control_M_AXI_RDATA,
  input  logic [1:0]          control_M_AXI_RRESP,
  input  logic                control_M_AXI_RVALID,
  output logic                control_M_AXI_RREADY
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_LIMIT);

  logic [2:0]           state;
  logic [AXI_ADDR-1:0]  addr_q;
  logic [BW_AXI-1:0]    wdata_q;
  logic [BWB_AXI-1:0]   wstrb_q;
  logic                 write_q;
  logic                 aw_pend;
  logic                 w_pend;
  logic [BW_AXI-1:0]    rdata_q;
  logic [1:0]           resp_q;
  logic                 timeout_q;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic [TIMEOUT_W-1:0] wait_inc;
  logic                 waiting;
  logic                 aw_done;
  logic                 w_done;

  assign waiting  = (state == S_WR_REQ) || (state == S_WR_RESP) ||
                    (state == S_RD_REQ) || (state == S_RD_DATA);
  assign wait_inc = (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;

  // A channel counts as done once its handshake happened earlier or is happening now.
  assign aw_done = !aw_pend || control_M_AXI_AWREADY;
  assign w_done  = !w_pend  || control_M_AXI_WREADY;

  always_ff @(posedge clk_control) begin
    if (clk_control_rst_high) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      rdata_q <= '0;
      resp_q  <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            write_q <= cmd_write;
            if (cmd_write) begin
              aw_pend <= 1'b1;
              w_pend  <= 1'b1;
              state   <= S_WR_REQ;
            end else begin
              state   <= S_RD_REQ;
            end
          end
        end
        S_WR_REQ: begin
          if (aw_pend && control_M_AXI_AWREADY) aw_pend <= 1'b0;
          if (w_pend && control_M_AXI_WREADY)   w_pend  <= 1'b0;
          if (aw_done && w_done)                state   <= S_WR_RESP;
        end
        S_WR_RESP: begin
          if (control_M_AXI_BVALID) begin
            resp_q  <= control_M_AXI_BRESP;
            rdata_q <= '0;
            state   <= S_RSP;
          end
        end
        S_RD_REQ: begin
          if (control_M_AXI_ARREADY) state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (control_M_AXI_RVALID) begin
            rdata_q <= control_M_AXI_RDATA;
            resp_q  <= control_M_AXI_RRESP;
            state   <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The limit only raises a sticky flag; the transaction keeps waiting for the slave.
  always_ff @(posedge clk_control) begin
    if (clk_control_rst_high) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if ((state == S_IDLE) && cmd_valid) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (waiting) begin
      wait_cnt <= wait_inc;
      if (wait_inc == LIMIT) timeout_q <= 1'b1;
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign timeout   = timeout_q;

  assign rsp_valid = (state == S_RSP);
  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

  assign control_M_AXI_AWADDR  = addr_q;
  assign control_M_AXI_AWVALID = aw_pend;
  assign control_M_AXI_WDATA   = wdata_q;
  assign control_M_AXI_WSTRB   = wstrb_q;
  assign control_M_AXI_WVALID  = w_pend;
  assign control_M_AXI_BREADY  = (state == S_WR_RESP);
  assign control_M_AXI_ARADDR  = addr_q;
  assign control_M_AXI_ARVALID = (state == S_RD_REQ);
  assign control_M_AXI_RREADY  = (state == S_RD_DATA);

endmodule

// File: tb/tb_axil_ctrl_master.sv
// Bench for axil_ctrl_master: a behavioural AXI-Lite slave with programmable stalls plus
// a command-level register model that predicts every response.
module tb_axil_ctrl_master;

  localparam int LIM = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy, timeout;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] model_mem [256];
  logic [31:0] slave_mem [256];

  bit fixed_mode = 1'b1;
  int fix_aw = 0, fix_w = 0, fix_b = 0, fix_ar = 0, fix_r = 0;
  bit b_hold = 1'b0, r_hold = 1'b0;
  int b_count = 0;

  bit s_aw_got, s_w_got, s_ar_got, s_applied, s_b_commit, s_r_commit;
  bit s_aw_wait, s_w_wait, s_ar_wait;
  int s_aw_st, s_w_st, s_b_st, s_ar_st, s_r_st;
  logic [7:0]  s_aw_a, s_ar_a, s_aw_prev, s_ar_prev;
  logic [31:0] s_w_d, s_w_prev_d;
  logic [3:0]  s_w_s, s_w_prev_s;

  always #5 clk = ~clk;

  axil_ctrl_master #(
    .AXI_ADDR(8), .BW_AXI(32), .BWB_AXI(4), .TIMEOUT_W(16), .TIMEOUT_LIMIT(LIM)
  ) dut (
    .clk_control(clk), .clk_control_rst_high(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy), .timeout(timeout),
    .control_M_AXI_AWADDR(awaddr), .control_M_AXI_AWVALID(awvalid),
    .control_M_AXI_AWREADY(awready), .control_M_AXI_WDATA(wdata),
    .control_M_AXI_WSTRB(wstrb), .control_M_AXI_WVALID(wvalid),
    .control_M_AXI_WREADY(wready), .control_M_AXI_BRESP(bresp),
    .control_M_AXI_BVALID(bvalid), .control_M_AXI_BREADY(bready),
    .control_M_AXI_ARADDR(araddr), .control_M_AXI_ARVALID(arvalid),
    .control_M_AXI_ARREADY(arready), .control_M_AXI_RDATA(rdata),
    .control_M_AXI_RRESP(rresp), .control_M_AXI_RVALID(rvalid),
    .control_M_AXI_RREADY(rready)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave response code depends only on the address, so the model can predict it.
  function automatic logic [1:0] respFor(input logic [7:0] a);
    case (a[5:4])
      2'd1:    return 2'd2;
      2'd2:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic int pickStall(input int fixed_val);
    return fixed_mode ? fixed_val : int'($urandom_range(0, 2));
  endfunction

  task automatic slaveClear();
    s_aw_got = 0; s_w_got = 0; s_ar_got = 0; s_applied = 0;
    s_b_commit = 0; s_r_commit = 0;
    s_aw_wait = 0; s_w_wait = 0; s_ar_wait = 0;
    s_aw_st = pickStall(fix_aw); s_w_st = pickStall(fix_w); s_b_st = pickStall(fix_b);
    s_ar_st = pickStall(fix_ar); s_r_st = pickStall(fix_r);
  endtask

  task automatic setPolicy(input bit fm, input int aw, input int w, input int b,
                           input int ar, input int r);
    fixed_mode = fm; fix_aw = aw; fix_w = w; fix_b = b; fix_ar = ar; fix_r = r;
    s_aw_st = pickStall(fix_aw); s_w_st = pickStall(fix_w); s_b_st = pickStall(fix_b);
    s_ar_st = pickStall(fix_ar); s_r_st = pickStall(fix_r);
  endtask

  // Slave: decides its READY/VALID at each falling edge; a handshake completes at the next rising edge.
  initial begin : slave
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; bresp = 0; rvalid = 0; rdata = 0; rresp = 0;
    slaveClear();
    forever begin
      @(negedge clk);
      awready = 0; wready = 0; arready = 0;
      if (rst) begin
        bvalid = 0; bresp = 0; rvalid = 0; rdata = 0; rresp = 0;
        slaveClear();
      end else begin
        if (s_aw_wait) checkOutput("aw_hold", 64'({awvalid, awaddr}), 64'({1'b1, s_aw_prev}));
        if (s_w_wait)  checkOutput("w_hold", 64'({wvalid, wstrb, wdata}),
                                   64'({1'b1, s_w_prev_s, s_w_prev_d}));
        if (s_ar_wait) checkOutput("ar_hold", 64'({arvalid, araddr}), 64'({1'b1, s_ar_prev}));
        if (s_aw_got)  checkOutput("aw_drop", 64'(awvalid), 64'(0));
        if (s_w_got)   checkOutput("w_drop", 64'(wvalid), 64'(0));
        if (s_ar_got)  checkOutput("ar_drop", 64'(arvalid), 64'(0));
        if (s_b_commit) begin
          b_count++; bvalid = 0; bresp = 0; slaveClear();
        end
        if (s_r_commit) begin
          rvalid = 0; rdata = 0; rresp = 0; slaveClear();
        end
        s_aw_wait = 0; s_w_wait = 0; s_ar_wait = 0;
        if (awvalid && !s_aw_got) begin
          if (s_aw_st == 0) begin awready = 1; s_aw_got = 1; s_aw_a = awaddr; end
          else begin s_aw_st--; s_aw_wait = 1; s_aw_prev = awaddr; end
        end
        if (wvalid && !s_w_got) begin
          if (s_w_st == 0) begin wready = 1; s_w_got = 1; s_w_d = wdata; s_w_s = wstrb; end
          else begin s_w_st--; s_w_wait = 1; s_w_prev_d = wdata; s_w_prev_s = wstrb; end
        end
        if (arvalid && !s_ar_got) begin
          if (s_ar_st == 0) begin arready = 1; s_ar_got = 1; s_ar_a = araddr; end
          else begin s_ar_st--; s_ar_wait = 1; s_ar_prev = araddr; end
        end
        if (s_aw_got && s_w_got && !s_applied) begin
          for (int b = 0; b < 4; b++)
            if (s_w_s[b]) slave_mem[s_aw_a][8*b +: 8] = s_w_d[8*b +: 8];
          s_applied = 1;
        end
        if (s_applied && !bvalid && !s_b_commit && !b_hold) begin
          if (s_b_st == 0) begin bvalid = 1; bresp = respFor(s_aw_a); end
          else s_b_st--;
        end
        if (s_ar_got && !rvalid && !s_r_commit && !r_hold) begin
          if (s_r_st == 0) begin rvalid = 1; rdata = slave_mem[s_ar_a]; rresp = respFor(s_ar_a); end
          else s_r_st--;
        end
        if (bvalid && bready) s_b_commit = 1;
        if (rvalid && rready) s_r_commit = 1;
      end
    end
  end

  // Presents one command at a falling edge and returns in the first cycle after acceptance.
  task automatic applyStimulus(input logic w, input logic [7:0] a, input logic [31:0] d,
                               input logic [3:0] s, output int waited);
    waited = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && waited < 50) begin @(negedge clk); waited++; end
    if (!cmd_ready) checkOutput("cmd_accept_bound", 64'(0), 64'(1));
    @(negedge clk);
    cmd_valid = 0;
    if (w)
      for (int b = 0; b < 4; b++)
        if (s[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic awaitResponse(input logic ew, input logic [31:0] erd, input logic [1:0] ers,
                               input logic eto, input int hold, inout int lat);
    while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
    checkOutput("rsp_valid", 64'(rsp_valid), 64'(1));
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("rsp_valid_held", 64'(rsp_valid), 64'(1));
      checkOutput("rsp_fields", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'({ew, ers, erd}));
      checkOutput("rsp_timeout", 64'(timeout), 64'(eto));
      checkOutput("rsp_cmd_ready", 64'({cmd_ready, busy}), 64'({1'b0, 1'b1}));
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    checkOutput("after_rsp", 64'({cmd_ready, rsp_valid, busy}), 64'({1'b1, 1'b0, 1'b0}));
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int lat, waited, bc;
    logic [31:0] d;
    logic [7:0] a;
    logic [3:0] s;
    logic w;

    for (int i = 0; i < 256; i++) begin
      model_mem[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'hC3};
      slave_mem[i] = model_mem[i];
    end
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl", 64'({cmd_ready, busy, timeout, rsp_valid}), 64'(4'b1000));
    checkOutput("reset_handshake", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'(0));
    checkOutput("reset_rsp", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'(0));
    checkOutput("reset_axi_bus", 64'({awaddr, araddr, wstrb, wdata}), 64'(0));
    rst = 0;
    @(negedge clk);

    // Basic write with an always-ready slave: minimum latency.
    setPolicy(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 8'h04, 32'hDEADBEEF, 4'hF, waited);
    checkOutput("w1_c1_valid", 64'({awvalid, wvalid, bready}), 64'(3'b110));
    checkOutput("w1_c1_bus", 64'({awaddr, wstrb, wdata}), 64'({8'h04, 4'hF, 32'hDEADBEEF}));
    @(negedge clk);
    checkOutput("w1_c2", 64'({awvalid, wvalid, bready}), 64'(3'b001));
    lat = 2;
    awaitResponse(1, 32'h0, 2'd0, 0, 0, lat);
    checkOutput("w1_latency", 64'(lat), 64'(3));

    // AWREADY delayed three cycles, WREADY immediate.
    setPolicy(1, 3, 0, 0, 0, 0);
    bc = b_count;
    applyStimulus(1, 8'h20, 32'hCAFEF00D, 4'b0101, waited);
    checkOutput("w2_c1", 64'({awvalid, wvalid}), 64'(2'b11));
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      checkOutput("w2_aw_held", 64'({awvalid, wvalid, awaddr}), 64'({2'b10, 8'h20}));
    end
    @(negedge clk);
    checkOutput("w2_c5", 64'({awvalid, wvalid, bready}), 64'(3'b001));
    lat = 5;
    awaitResponse(1, 32'h0, respFor(8'h20), 0, 0, lat);
    repeat (2) @(negedge clk);
    checkOutput("w2_single_b", 64'(b_count - bc), 64'(1));

    // Read with SLVERR passed through.
    setPolicy(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 8'h10, 32'h12345678, 4'hF, waited);
    lat = 1;
    awaitResponse(1, 32'h0, 2'd2, 0, 0, lat);
    applyStimulus(0, 8'h10, 32'h0, 4'h0, waited);
    checkOutput("r1_c1", 64'({arvalid, araddr}), 64'({1'b1, 8'h10}));
    lat = 1;
    awaitResponse(0, 32'h12345678, 2'd2, 0, 0, lat);
    checkOutput("r1_latency", 64'(lat), 64'(3));

    // Response back-pressure, then an immediate follow-on command.
    applyStimulus(0, 8'h04, 32'h0, 4'h0, waited);
    lat = 1;
    awaitResponse(0, model_mem[8'h04], 2'd0, 0, 5, lat);
    d = $urandom;
    applyStimulus(1, 8'h30, d, 4'hF, waited);
    checkOutput("next_cmd_wait", 64'(waited), 64'(0));
    lat = 1;
    awaitResponse(1, 32'h0, respFor(8'h30), 0, 0, lat);

    // Stuck B channel raises the sticky timeout without aborting.
    b_hold = 1;
    d = $urandom;
    applyStimulus(1, 8'h08, d, 4'hF, waited);
    for (int c = 1; c <= 12; c++) begin
      if (c == 8) checkOutput("to_before_limit", 64'(timeout), 64'(0));
      if (c == 9) checkOutput("to_at_limit", 64'(timeout), 64'(1));
      if (c == 12) checkOutput("to_still_waiting", 64'({busy, timeout, bready}), 64'(3'b111));
      if (c < 12) @(negedge clk);
    end
    b_hold = 0;
    lat = 12;
    awaitResponse(1, 32'h0, 2'd0, 1, 0, lat);
    checkOutput("to_sticky_idle", 64'(timeout), 64'(1));
    applyStimulus(0, 8'h08, 32'h0, 4'h0, waited);
    checkOutput("to_cleared", 64'(timeout), 64'(0));
    lat = 1;
    awaitResponse(0, model_mem[8'h08], 2'd0, 0, 0, lat);

    // Reset while waiting for read data.
    r_hold = 1;
    applyStimulus(0, 8'h10, 32'h0, 4'h0, waited);
    checkOutput("rst_c1", 64'(arvalid), 64'(1));
    @(negedge clk);
    checkOutput("rst_rd_data", 64'({rready, busy}), 64'(2'b11));
    rst = 1;
    @(negedge clk);
    checkOutput("rst_ctrl", 64'({rready, busy, cmd_ready, rsp_valid}), 64'(4'b0010));
    checkOutput("rst_handshake", 64'({awvalid, wvalid, arvalid, bready}), 64'(0));
    @(negedge clk);
    rst = 0;
    r_hold = 0;
    @(negedge clk);

    // Randomised traffic against the register model.
    setPolicy(0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 15) * 4);
      d = $urandom;
      s = 4'($urandom);
      applyStimulus(w, a, d, s, waited);
      lat = 1;
      if (w) awaitResponse(1, 32'h0, respFor(a), 0, int'($urandom_range(0, 3)), lat);
      else   awaitResponse(0, model_mem[a], respFor(a), 0, int'($urandom_range(0, 3)), lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axil_ctrl_master.md
# axil_ctrl_master

AXI4-Lite initiator that drives a tile's `control_S_AXI_*` slave port from a simple command/response stream. It sits on the host/control side, one instance per tile control port. It converts one command (register write or read) into the matching AW/W/B or AR/R handshakes and returns the completion on a response stream. It allows exactly one outstanding transaction and flags a stuck slave with a timeout.

## Interface
- `AXI_ADDR`, 8, control address width
- `BW_AXI`, 32, control data width
- `BWB_AXI`, `BW_AXI/8`, write-strobe width
- `TIMEOUT_W`, 16, width of the wait-cycle counter
- `TIMEOUT_LIMIT`, 1000, wait cycles before the `timeout` status is raised; must be less than 2^TIMEOUT_W
- `clk_control`  in  1  control clock; the only clock in the block
- `clk_control_rst_high`  in  1  synchronous, active-high reset
- `cmd_valid` / `cmd_ready`  in/out  1  command handshake
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  AXI_ADDR  register address
- `cmd_wdata`  in  BW_AXI  write data; ignored for reads
- `cmd_wstrb`  in  BWB_AXI  write strobes; ignored for reads
- `rsp_valid` / `rsp_ready`  out/in  1  response handshake
- `rsp_write`  out  1  echo of `cmd_write`
- `rsp_rdata`  out  BW_AXI  read data; 0 for writes
- `rsp_resp`  out  2  BRESP or RRESP
- `busy`  out  1  high in any state other than IDLE
- `timeout`  out  1  sticky: the current or last transaction waited TIMEOUT_LIMIT cycles
- `control_M_AXI_AWADDR`/`AWVALID`/`AWREADY`  out/out/in  AXI_ADDR/1/1
- `control_M_AXI_WDATA`/`WSTRB`/`WVALID`/`WREADY`  out/out/out/in  BW_AXI/BWB_AXI/1/1
- `control_M_AXI_BRESP`/`BVALID`/`BREADY`  in/in/out  2/1/1
- `control_M_AXI_ARADDR`/`ARVALID`/`ARREADY`  out/out/in  AXI_ADDR/1/1
- `control_M_AXI_RDATA`/`RRESP`/`RVALID`/`RREADY`  in/in/in/out  BW_AXI/2/1/1

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch addr, wdata, wstrb and write into registers, clear `timeout` and the wait counter.
  - Go to WR_REQ if the command is a write, otherwise RD_REQ.
- WR_REQ:
  - AWVALID and WVALID both rise; each has its own pending flag.
  - Each valid drops in the cycle after its own handshake, independently of the other.
  - AW and W may complete in the same cycle or in either order.
  - When both are complete, go to WR_RESP.
- WR_RESP:
  - BREADY=1.
  - On BVALID, capture BRESP into `rsp_resp`, set `rsp_rdata`=0, go to RSP.
- RD_REQ:
  - ARVALID=1 until ARREADY, then go to RD_DATA.
- RD_DATA:
  - RREADY=1.
  - On RVALID, capture RDATA and RRESP, go to RSP.
- RSP:
  - `rsp_valid`=1; all response fields are held stable.
  - On `rsp_ready`, go to IDLE.
- AXI address/data outputs come from the latched registers and stay stable while the matching VALID is high. A VALID is never withdrawn before its READY.
- Wait counter:
  - Increments each cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - Saturates at all-ones.
  - When it equals TIMEOUT_LIMIT, `timeout` is set.
  - Reaching the limit does not abort the transaction; the block keeps waiting.
- A non-OKAY response (SLVERR/DECERR) is passed through in `rsp_resp`; it is not an error inside the block.

## Timing
- Reset values:
  - State IDLE; all VALID/READY outputs are 0 except `cmd_ready`=1.
  - `rsp_*`=0, `busy`=0, `timeout`=0, counter 0, AXI address/data/strobe outputs 0.
- All outputs are registered or decoded from the registered state. There is no combinational path from any input to any output.
- Command accepted at edge 0:
  - AWVALID/WVALID (or ARVALID) high in cycle 1.
  - With READY already high, BREADY/RREADY is high in cycle 2.
  - With BVALID/RVALID in cycle 2, `rsp_valid` is high in cycle 3.
  - Minimum command-to-response latency is 3 cycles; `cmd_ready` returns in the cycle after the response handshake.
- `cmd_ready`=0 whenever `busy`=1; back-to-back commands are therefore spaced at least 4 cycles apart.
- BVALID or RVALID arriving in the same cycle the request handshake completes is not consumed; it is accepted in the first cycle of WR_RESP/RD_DATA. The slave must hold it per AXI.
- Reset mid-transaction: in the next cycle every VALID and READY output is 0 and the state is IDLE. The attached slave shares this reset.

## Test plan
- Write addr 0x04, data 0xDEADBEEF, strb 0xF, slave always ready, BRESP=0 -> AW/W valid in cycle 1, BREADY in cycle 2, `rsp_valid` in cycle 3 with resp 0, rdata 0.
- Write with AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops after cycle 1, AWVALID held with AWADDR stable through cycle 4, then a single B handshake.
- Read addr 0x10, slave returns RDATA 0x12345678, RRESP=2 -> `rsp_rdata`=0x12345678, `rsp_resp`=2, `rsp_write`=0.
- `rsp_ready` held low for 5 cycles -> `rsp_valid` and all response fields stable; `cmd_ready`=0 throughout; next command accepted 1 cycle after `rsp_ready`.
- TIMEOUT_LIMIT=8, slave never asserts BVALID -> `timeout`=1 after 8 wait cycles while `busy` stays 1. BVALID later -> normal completion with `timeout` still 1; the next accepted command clears it.
- Assert reset during RD_DATA -> next cycle RREADY=0, `busy`=0, `cmd_ready`=1, `rsp_valid`=0.
